// File: rtl/actuator_matrix_sequencer.sv
// Purpose: timed set/clear scan sequencer for an N_ROWS x N_COLS bistable dot matrix with delta-only drive and abort.
// Latency: 2-flop trigger sync + edge detect, then LOAD; the first drive phase starts the cycle after LOAD; all outputs registered.
// Backpressure: triggers seen while busy are dropped (no queuing); enable low aborts to IDLE with all bridges hi-Z.
module actuator_matrix_sequencer #(
  parameter int N_ROWS = 5,
  parameter int N_COLS = 2,
  parameter int CNT_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       trigger_in_n,
  input  logic                       past_state_mode,
  input  logic                       invert_mode,
  input  logic [N_ROWS*N_COLS-1:0]   state_in,
  input  logic [CNT_W-1:0]           dead_cycles,
  input  logic [CNT_W-1:0]           pulse_cycles,
  input  logic [CNT_W-1:0]           done_cycles,
  output logic [N_ROWS-1:0]          row_p,
  output logic [N_ROWS-1:0]          row_n,
  output logic [N_COLS-1:0]          col_p,
  output logic [N_COLS-1:0]          col_n,
  output logic                       busy,
  output logic                       trigger_out_n,
  output logic [N_ROWS*N_COLS-1:0]   committed_state
);

  localparam int NDOT  = N_ROWS * N_COLS;
  localparam int NSTEP = 2 * N_COLS;
  localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int SW    = $clog2(NSTEP) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SET_DRV, S_SET_DEAD, S_CLR_DRV, S_CLR_DEAD, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_load, phase_len;
  logic               cnt_zero;
  logic               advance;

  logic               trig_meta, trig_sync, trig_prev, trig_fall;

  logic [NDOT-1:0]    target_q;
  logic               past_q;
  logic [CNT_W-1:0]   dead_q, pulse_q, done_q;

  logic [NDOT-1:0]                drive_sel;
  logic [N_COLS-1:0][N_ROWS-1:0]  set_m, clr_m;
  logic [NSTEP-1:0]               act;
  logic [SW-1:0]                  search_start, first_step;
  logic                           found;

  logic [N_ROWS-1:0]  row_p_d, row_n_d;
  logic [N_COLS-1:0]  col_p_d, col_n_d;

  assign cnt_zero  = (cnt_q == '0);
  assign trig_fall = trig_prev & ~trig_sync;

  // Two-flop synchroniser for the pad trigger plus a history flop for falling-edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trig_meta <= 1'b1;
      trig_sync <= 1'b1;
      trig_prev <= 1'b1;
    end else begin
      trig_meta <= trigger_in_n;
      trig_sync <= trig_meta;
      trig_prev <= trig_sync;
    end
  end

  // Snapshot pattern, mode and timing words on entry to LOAD so later input changes are ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      target_q <= '0;
      past_q   <= 1'b0;
      dead_q   <= '0;
      pulse_q  <= '0;
      done_q   <= '0;
    end else if (state_d == S_LOAD) begin
      target_q <= invert_mode ? ~state_in : state_in;
      past_q   <= past_state_mode;
      dead_q   <= dead_cycles;
      pulse_q  <= pulse_cycles;
      done_q   <= done_cycles;
    end
  end

  // Per-column set/clear row masks; step 2c is column c's set phase, 2c+1 its clear phase.
  always_comb begin
    set_m     = '0;
    clr_m     = '0;
    act       = '0;
    drive_sel = past_q ? (target_q ^ committed_state) : {NDOT{1'b1}};
    for (int c = 0; c < N_COLS; c++) begin
      set_m[c]       =  target_q[c*N_ROWS +: N_ROWS] & drive_sel[c*N_ROWS +: N_ROWS];
      clr_m[c]       = ~target_q[c*N_ROWS +: N_ROWS] & drive_sel[c*N_ROWS +: N_ROWS];
      act[2*c]       = ~past_q | (|set_m[c]);
      act[2*c + 1]   = ~past_q | (|clr_m[c]);
    end
  end

  // Find the lowest-numbered phase still to run at or after the current position; empty phases are skipped in past mode.
  always_comb begin
    search_start = '0;
    case (state_q)
      S_SET_DEAD: search_start = SW'({col_q, 1'b0}) + SW'(1);
      S_CLR_DEAD: search_start = SW'({col_q, 1'b0}) + SW'(2);
      default:    search_start = '0;
    endcase
    found      = 1'b0;
    first_step = '0;
    for (int s = NSTEP - 1; s >= 0; s--) begin
      if (s >= int'(search_start) && act[s]) begin
        found      = 1'b1;
        first_step = SW'(s);
      end
    end
  end

  // Next-state logic: phase sequencing, with enable low overriding everything back to IDLE.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE:     if (trig_fall) state_d = S_LOAD;
      S_LOAD:     advance = 1'b1;
      S_SET_DRV:  if (cnt_zero) state_d = S_SET_DEAD;
      S_SET_DEAD: advance = cnt_zero;
      S_CLR_DRV:  if (cnt_zero) state_d = S_CLR_DEAD;
      S_CLR_DEAD: advance = cnt_zero;
      S_DONE:     if (cnt_zero) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (advance) begin
      if (found) begin
        col_d   = CW'(first_step >> 1);
        state_d = first_step[0] ? S_CLR_DRV : S_SET_DRV;
      end else begin
        state_d = S_DONE;
      end
    end
    if (!enable) state_d = S_IDLE;
  end

  // Phase length for the state being entered; a zero timing word still gives one cycle.
  always_comb begin
    case (state_d)
      S_SET_DRV, S_CLR_DRV:   phase_len = pulse_q;
      S_SET_DEAD, S_CLR_DEAD: phase_len = dead_q;
      S_DONE:                 phase_len = done_q;
      default:                phase_len = '0;
    endcase
    cnt_load = (phase_len == '0) ? '0 : phase_len - CNT_W'(1);
  end

  // State register with the phase down-counter, reloaded on every state change.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      if (state_d != state_q) cnt_q <= cnt_load;
      else if (!cnt_zero)     cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Bridge drive decoded from the next state so registered outputs line up with the state they belong to.
  always_comb begin
    row_p_d = '1;
    row_n_d = '0;
    col_p_d = '1;
    col_n_d = '0;
    case (state_d)
      S_SET_DRV: begin
        col_p_d[col_d] = 1'b0;
        row_n_d        = set_m[col_d];
      end
      S_CLR_DRV: begin
        col_n_d[col_d] = 1'b1;
        row_p_d        = ~clr_m[col_d];
      end
      default: ;
    endcase
  end

  // Output registers; the pattern is committed on DONE entry and survives a later abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      row_p           <= '1;
      row_n           <= '0;
      col_p           <= '1;
      col_n           <= '0;
      busy            <= 1'b0;
      trigger_out_n   <= 1'b1;
      committed_state <= '0;
    end else begin
      row_p         <= row_p_d;
      row_n         <= row_n_d;
      col_p         <= col_p_d;
      col_n         <= col_n_d;
      busy          <= (state_d != S_IDLE);
      trigger_out_n <= (state_d != S_DONE);
      if (state_d == S_DONE && state_q != S_DONE) committed_state <= target_q;
    end
  end

endmodule
